instr_encoder: RTL and testbench

- Assembles 32-bit RV32I instruction words from decoded fields: format, opcode, funct3, funct7, register indices and a full 32-bit immediate.
- Scatters the immediate into instruction bits 31:7. This is the exact inverse of the immediate generator's bit gathering.
- Used by the boot/test program loader to write instruction memory. Its output is the word the datapath later decodes.
- Buffers encoded words in a small FIFO and tags each output word with a sequential byte address.

---
 rtl/instr_encoder.sv | 122 ++++++++++++
 tb/tb_instr_encoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction word encoder with addressed output FIFO
// Optional macro INSTR_ENC_RANGE_CHECK_EN enables immediate range/alignment rejection.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   addr_q, last_q;
  logic          err_q;
  logic [7:0]    err_cnt_q;
  logic [31:0]   word;
  logic          fmt_ok, legal, full, accept, push, pop;

  always_comb begin
    word   = 32'h0;
    fmt_ok = 1'b1;
    case (fmt)
      3'b000:  word = {imm[11:0], rs1, funct3, rd, opcode};
      3'b001:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'b010:  word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'b011:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      3'b100:  word = {funct7, rs2, rs1, funct3, rd, opcode};
      3'b101:  word = {imm[31:12], rd, opcode};
      default: fmt_ok = 1'b0;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic signed [31:0] simm;
  logic               range_ok;
  assign simm = imm;

  always_comb begin
    range_ok = 1'b1;
    case (fmt)
      3'b000, 3'b001: range_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
      3'b010:         range_ok = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
      3'b011:         range_ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];
      3'b101:         range_ok = (imm[11:0] == 12'h000);
      default:        range_ok = 1'b1;
    endcase
  end

  assign legal = fmt_ok && range_ok;
`else
  assign legal = fmt_ok;
`endif

  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign in_ready  = !full && !flush;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready && !flush;

  // last_q keeps the most recently presented head so out_data holds once empty
  assign out_data = out_valid ? mem[rd_ptr] : last_q;
  assign out_addr = addr_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      addr_q    <= BASE_ADDR;
      last_q    <= 32'h0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      err_q <= accept && !legal;
      if (accept && !legal && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        addr_q <= BASE_ADDR;
        if (out_valid) last_q <= mem[rd_ptr];
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          addr_q <= addr_q + 32'd4;
          last_q <= mem[rd_ptr];
        end
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
// Expectations follow INSTR_ENC_RANGE_CHECK_EN when defined for the build.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, err;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, out_data, out_addr;
  logic [7:0]  err_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [31:0] im);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im);
    set_fields(f, op, f3, f7, d, s1, s2, im);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] cnt_exp;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(3'b000, 7'h00, 3'h0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0);
    #12;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    send(3'b000, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    check("i_valid", {31'h0, out_valid}, 32'h1);
    check("i_data", out_data, 32'h00500093);
    check("i_addr", out_addr, 32'h0);
    pop1();
    check("i_pop_empty", {31'h0, out_valid}, 32'h0);
    check("i_pop_addr", out_addr, 32'h4);
    check("i_hold_data", out_data, 32'h00500093);
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush_addr", out_addr, 32'h0);

    send(3'b001, 7'b0100011, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8);
    send(3'b010, 7'b1100011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, -32'sd4);
    check("s_data", out_data, 32'h0020A423);
    check("s_addr", out_addr, 32'h0);
    tick();
    check("s_stall_data", out_data, 32'h0020A423);
    check("s_stall_addr", out_addr, 32'h0);
    pop1();
    check("b_data", out_data, 32'hFE000EE3);
    check("b_addr", out_addr, 32'h4);
    pop1();
    check("sb_empty", {31'h0, out_valid}, 32'h0);

    send(3'b011, 7'b1101111, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
    check("j_data", out_data, 32'h001000EF);
    check("j_addr", out_addr, 32'h8);
    pop1();
    send(3'b100, 7'b0110011, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF);
    check("r_data", out_data, 32'h002081B3);
    pop1();
    send(3'b101, 7'b0110111, 3'b000, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000);
    check("u_data", out_data, 32'h123452B7);
    pop1();
    send(3'b000, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, -32'sd2048);
    check("i_min_data", out_data, 32'h80000093);
    pop1();

    send(3'b011, 7'b1101111, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    check("j_odd_err", {31'h0, err}, 32'h1);
    check("j_odd_cnt", {24'h0, err_cnt}, 32'h1);
    check("j_odd_nopush", {31'h0, out_valid}, 32'h0);
    tick();
    check("j_odd_err_clr", {31'h0, err}, 32'h0);
`else
    check("j_odd_err", {31'h0, err}, 32'h0);
    check("j_odd_data", out_data, 32'h002000EF);
    pop1();
`endif

    send(3'b000, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    check("i_big_err", {31'h0, err}, 32'h1);
    check("i_big_cnt", {24'h0, err_cnt}, 32'h2);
    check("i_big_nopush", {31'h0, out_valid}, 32'h0);
    cnt_exp = 8'd3;
`else
    check("i_big_data", out_data, 32'h80000093);
    pop1();
    cnt_exp = 8'd1;
`endif

    send(3'b110, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0);
    check("fmt_err", {31'h0, err}, 32'h1);
    check("fmt_cnt", {24'h0, err_cnt}, {24'h0, cnt_exp});
    check("fmt_nopush", {31'h0, out_valid}, 32'h0);
    tick();
    check("fmt_err_clr", {31'h0, err}, 32'h0);

    flush = 1'b1; tick(); flush = 1'b0;
    for (int k = 1; k <= 4; k++) send(3'b000, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, k);
    check("full_in_ready", {31'h0, in_ready}, 32'h0);
    check("full_head", out_data, 32'h00100093);
    set_fields(3'b000, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("drain0_data", out_data, 32'h00200093);
    check("drain0_addr", out_addr, 32'h4);
    check("drain0_ready", {31'h0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    check("drain1_data", out_data, 32'h00300093);
    check("drain1_addr", out_addr, 32'h8);
    tick();
    check("drain2_data", out_data, 32'h00400093);
    check("drain2_addr", out_addr, 32'hC);
    tick();
    check("drain3_data", out_data, 32'h00500093);
    check("drain3_addr", out_addr, 32'h10);
    tick();
    out_ready = 1'b0;
    check("drain_empty", {31'h0, out_valid}, 32'h0);

    for (int k = 6; k <= 8; k++) send(3'b000, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, k);
    set_fields(3'b000, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd9);
    in_valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_in_ready", {31'h0, in_ready}, 32'h0);
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_valid", {31'h0, out_valid}, 32'h0);
    check("flush_addr2", out_addr, 32'h0);
    check("flush_cnt_kept", {24'h0, err_cnt}, {24'h0, cnt_exp});
    tick();
    check("flush_no_accept", {31'h0, out_valid}, 32'h0);

    send(3'b000, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1);
    pop1();
    send(3'b000, 7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'h0, out_valid}, 32'h0);
    check("arst_data", out_data, 32'h0);
    check("arst_addr", out_addr, 32'h0);
    check("arst_cnt", {24'h0, err_cnt}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_after", {31'h0, out_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
